regfile32x32: RTL and testbench

Integer register file for the NovaEdge32 core: 32 × 32-bit architectural registers with one synchronous write port and two combinational read ports. Storage is flip-flop based. Each read port is a bit-sliced bank of 32 one-bit 32:1 selectors (`mux32x5`), so this block directly feeds the selector stage and is the state it consumes. Register x0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_read_port.sv | 39 +++
 rtl/regfile32x32.sv | 79 +++++++
 tb/tb_regfile32x32.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and types for the NovaEdge32 integer register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;

  // Full architectural view, entry 0 included, as consumed by the selectors.
  typedef logic [NREGS-1:0][XLEN-1:0] reg_array_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // True when a write request actually targets storage (x0 has none).
  function automatic logic is_real_write(input logic we, input reg_addr_t waddr);
    return we && (waddr != ZERO_REG);
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: 32 bit-sliced 1-bit 32:1 selectors over the register array.
// Latency: zero cycles, address -> selector tree -> data.
// Backpressure: none; always accepts an address and always produces data.

// Single-bit 32:1 selector; in[i] is bit b of register i.
module mux32x5 (
  input  logic [31:0] in,
  input  logic [4:0]  sel,
  output logic        out
);

  assign out = in[sel];

endmodule : mux32x5

module regfile_read_port
  import regfile_pkg::*;
(
  input  reg_array_t regs,
  input  reg_addr_t  addr,
  output xword_t     data
);

  for (genvar b = 0; b < XLEN; b++) begin : g_bit
    logic [NREGS-1:0] slice;

    // Gather bit b of every register into the selector input vector.
    for (genvar i = 0; i < NREGS; i++) begin : g_gather
      assign slice[i] = regs[i][b];
    end

    mux32x5 u_mux (
      .in  (slice),
      .sel (addr),
      .out (data[b])
    );
  end

endmodule : regfile_read_port

// File: rtl/regfile32x32.sv
// 32x32 integer register file: one synchronous write port, two combinational read ports, x0 = 0.
// Latency: write commits on the next rising edge; reads are zero-cycle combinational.
// Backpressure: none. Optional write-forwarding to the read ports under REGFILE_BYPASS_EN.
module regfile32x32
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we,
  input  reg_addr_t waddr,
  input  xword_t    wdata,
  input  reg_addr_t raddr1,
  input  reg_addr_t raddr2,
  output xword_t    rdata1,
  output xword_t    rdata2
);

  // Storage exists only for x1..x31.
  logic [NREGS-1:1][XLEN-1:0] regs_q;
  logic [NREGS-1:1][XLEN-1:0] regs_d;
  reg_array_t                 rd_arr;
  xword_t                     port_dat1;
  xword_t                     port_dat2;
  logic                       wr_hit;

  assign wr_hit = is_real_write(we, waddr);

  // Next-state: only the addressed register changes; x0 writes fall away.
  always_comb begin
    regs_d = regs_q;
    if (wr_hit) begin
      regs_d[waddr] = wdata;
    end
  end

  // Register state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Selector view: x0 input is tied to zero so every selector input is driven.
  assign rd_arr = {regs_q, {XLEN{1'b0}}};

  regfile_read_port u_rp1 (
    .regs (rd_arr),
    .addr (raddr1),
    .data (port_dat1)
  );

  regfile_read_port u_rp2 (
    .regs (rd_arr),
    .addr (raddr2),
    .data (port_dat2)
  );

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  // Forward the in-flight write; suppressed in reset since that write will not commit.
  always_comb begin
    fwd1   = rst_n && wr_hit && (waddr == raddr1);
    fwd2   = rst_n && wr_hit && (waddr == raddr2);
    rdata1 = fwd1 ? wdata : port_dat1;
    rdata2 = fwd2 ? wdata : port_dat2;
  end
`else
  // No forwarding: same-cycle reads see the pre-write value.
  always_comb begin
    rdata1 = port_dat1;
    rdata2 = port_dat2;
  end
`endif

endmodule : regfile32x32

// File: tb/tb_regfile32x32.sv
module tb_regfile32x32;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  // Architectural model: plain array, x0 kept at 0.
  logic [31:0] model [32];

  int n_chk;
  int n_bad;

  regfile32x32 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_dat(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // Expected read value from the rules: x0 is zero, reset forces zero,
  // bypass builds see the pending write, otherwise stored contents.
  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (!rst_n) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clk);
    if (rst_n && a != 5'd0) model[a] = d;
    #1 we = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      chk_dat({tag, "_p1"}, rdata1, ref_rd(raddr1));
      chk_dat({tag, "_p2"}, rdata2, ref_rd(raddr2));
    end
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    clear_model();

    // Reset state.
    #2 check_all("rst_init");
    @(negedge clk); rst_n = 1'b1;

    // Arbitrary contents, then a mid-cycle reset with a write presented during it.
    for (int i = 0; i < 8; i++) do_write(5'($urandom_range(1, 31)), $urandom);
    do_write(5'd7, 32'h7777_7777);
    @(posedge clk); #3 rst_n = 1'b0; clear_model();
    #1 check_all("rst_async");
    @(negedge clk); we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 we = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    raddr1 = 5'd7; #1 chk_dat("rst_wr_ignored", rdata1, 32'h0);
    check_all("rst_after");

    // Write/read sweep.
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'hA5A5_0000 | i);
    check_all("sweep");

    // x0 protection.
    do_write(5'd0, 32'hFFFF_FFFF);
    raddr1 = 5'd0; #1 chk_dat("x0_rd", rdata1, 32'h0);
    check_all("x0_others");

    // Same-cycle hazard on reg 5.
    do_write(5'd5, 32'h1111_1111);
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'h2222_2222; raddr1 = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk_dat("haz_pre", rdata1, 32'h2222_2222);
`else
    chk_dat("haz_pre", rdata1, 32'h1111_1111);
`endif
    @(posedge clk); model[5] = 32'h2222_2222;
    #1 we = 1'b0;
    #1 chk_dat("haz_post", rdata1, 32'h2222_2222);

    // Walking one: one bit per register, each in its own slice.
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'h1 << i);
    check_all("walk");
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i);
      #1;
      chk_dat("walk_pop", 32'($countones(rdata1)), 32'd1);
      chk_dat("walk_same", rdata2, 32'h1 << i);
    end

    // Random traffic with occasional sub-cycle reset pulses.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we     = 1'($urandom_range(0, 1));
      waddr  = 5'($urandom);
      wdata  = $urandom;
      raddr1 = 5'($urandom);
      raddr2 = (n % 4 == 0) ? waddr : 5'($urandom);
      #1;
      chk_dat("rnd_p1", rdata1, ref_rd(raddr1));
      chk_dat("rnd_p2", rdata2, ref_rd(raddr2));
      @(posedge clk);
      if (we && waddr != 5'd0) model[waddr] = wdata;
      #1 we = 1'b0;
      if (n % 60 == 30) begin
        #1 rst_n = 1'b0; clear_model();
        #1 rst_n = 1'b1;
        check_all("rnd_rst");
        do_write(5'd9, 32'h0BAD_CAFE);
        raddr1 = 5'd9; #1 chk_dat("rnd_rst_wr", rdata1, 32'h0BAD_CAFE);
      end
    end
    check_all("rnd_final");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_regfile32x32
